// File: rtl/dcpu16_run_pkg.sv
// Shared types for the DCPU-16 run controller: FSM states, termination codes
// and the default success sentinel.
package dcpu16_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CORE_RST = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT     = 3'd3,
    S_DONE     = 3'd4
  } run_state_e;

  typedef enum logic [2:0] {
    ST_NONE       = 3'd0,
    ST_SUCCESS    = 3'd1,
    ST_ILLEGAL    = 3'd2,
    ST_BREAKPOINT = 3'd3,
    ST_LIMIT      = 3'd4,
    ST_ABORT      = 3'd5
  } run_status_e;

  localparam logic [15:0] DEFAULT_SUCCESS_CODE = 16'h3FF0;

endpackage

// File: rtl/dcpu16_bp_match.sv
// Combinational PC breakpoint compare: hit when any enabled breakpoint
// address equals the supplied PC.
module dcpu16_bp_match #(
  parameter int WORD_W = 16,
  parameter int NUM_BP = 2
) (
  input  logic [WORD_W-1:0]        pc_i,
  input  logic [NUM_BP*WORD_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  output logic                     hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en_i[i] && (bp_addr_i[i*WORD_W +: WORD_W] == pc_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/dcpu16_run_ctrl.sv
// DCPU-16 run controller: sequences core reset, issues single-instruction
// steps, classifies termination and keeps saturating instruction/cycle counts.
module dcpu16_run_ctrl
  import dcpu16_run_pkg::*;
#(
  parameter int                WORD_W       = 16,
  parameter logic [WORD_W-1:0] SUCCESS_CODE = WORD_W'(DEFAULT_SUCCESS_CODE),
  parameter int                CNT_W        = 32,
  parameter int                NUM_BP       = 2,
  parameter int                RST_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     single_step,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         step_limit,
  input  logic [NUM_BP*WORD_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  output logic                     core_rst_o,
  output logic                     step_o,
  input  logic                     step_done_i,
  input  logic [WORD_W-1:0]        pc_i,
  input  logic [WORD_W-1:0]        instr_i,
  input  logic                     illegal_i,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               status,
  output logic [CNT_W-1:0]         instr_count,
  output logic [CNT_W-1:0]         cycle_count
);

  localparam int                RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RST_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  run_state_e       state_q, state_d;
  run_status_e      status_q, status_d;
  logic [CNT_W-1:0] instr_q, instr_d, cyc_q, cyc_d, limit_q, limit_d, new_cnt;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             ss_q, ss_d;
  logic             core_rst_q, step_q, busy_q, done_q;
  logic             bp_hit;

  dcpu16_bp_match #(
    .WORD_W (WORD_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc_i      (pc_i),
    .bp_addr_i (bp_addr),
    .bp_en_i   (bp_en),
    .hit_o     (bp_hit)
  );

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    instr_d   = instr_q;
    cyc_d     = busy_q ? sat_inc(cyc_q) : cyc_q;
    limit_d   = limit_q;
    rst_cnt_d = rst_cnt_q;
    ss_d      = ss_q;
    new_cnt   = sat_inc(instr_q);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = single_step ? S_ISSUE : S_CORE_RST;
          status_d  = ST_NONE;
          instr_d   = '0;
          cyc_d     = '0;
          rst_cnt_d = '0;
          ss_d      = single_step;
          limit_d   = step_limit;
        end
      end
      S_CORE_RST: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (rst_cnt_q == RC_LAST) begin
          state_d = S_ISSUE;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion in the same cycle as abort is classified normally.
        if (step_done_i) begin
          instr_d = new_cnt;
          state_d = S_DONE;
          if (illegal_i && (instr_i == SUCCESS_CODE))   status_d = ST_SUCCESS;
          else if (illegal_i)                           status_d = ST_ILLEGAL;
          else if (bp_hit)                              status_d = ST_BREAKPOINT;
          else if ((limit_q != '0) && (new_cnt == limit_q)) status_d = ST_LIMIT;
          else if (ss_q)                                status_d = ST_NONE;
          else                                          state_d  = S_ISSUE;
        end else if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      status_q   <= ST_NONE;
      instr_q    <= '0;
      cyc_q      <= '0;
      limit_q    <= '0;
      rst_cnt_q  <= '0;
      ss_q       <= 1'b0;
      core_rst_q <= 1'b0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      instr_q    <= instr_d;
      cyc_q      <= cyc_d;
      limit_q    <= limit_d;
      rst_cnt_q  <= rst_cnt_d;
      ss_q       <= ss_d;
      core_rst_q <= (state_d == S_CORE_RST);
      step_q     <= (state_d == S_ISSUE);
      busy_q     <= (state_d == S_CORE_RST) || (state_d == S_ISSUE) || (state_d == S_WAIT);
      done_q     <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  assign core_rst_o  = core_rst_q;
  assign step_o      = step_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign instr_count = instr_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_dcpu16_run_ctrl.sv
// Bench for dcpu16_run_ctrl: a stepping core responder plus a step-list
// reference model; a second instance with 4-bit counters covers saturation.
module tb_dcpu16_run_ctrl;

  localparam int          RST = 4;
  localparam logic [15:0] SC  = 16'h3FF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, single_step = 1'b0, abort = 1'b0;
  logic [31:0] step_limit = '0;
  logic [31:0] bp_addr = '0;
  logic [1:0]  bp_en = '0;
  logic        step_done_i = 1'b0, illegal_i = 1'b0;
  logic [15:0] pc_i = '0, instr_i = '0;
  logic        core_rst_o, step_o, busy, done;
  logic [2:0]  status;
  logic [31:0] instr_count, cycle_count;

  logic        start_s = 1'b0, step_done_s = 1'b0;
  logic [3:0]  limit_s = '0;
  logic        s_core_rst, s_step, s_busy, s_done;
  logic [2:0]  s_status;
  logic [3:0]  s_icnt, s_ccnt;

  int checks = 0;
  int errors = 0;

  logic        s_ill [32];
  logic [15:0] s_ins [32];
  logic [15:0] s_pc  [32];
  int          s_dly [32];

  always #5 clk = ~clk;

  dcpu16_run_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .single_step(single_step), .abort(abort),
    .step_limit(step_limit), .bp_addr(bp_addr), .bp_en(bp_en),
    .core_rst_o(core_rst_o), .step_o(step_o), .step_done_i(step_done_i),
    .pc_i(pc_i), .instr_i(instr_i), .illegal_i(illegal_i),
    .busy(busy), .done(done), .status(status),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  dcpu16_run_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .single_step(1'b0), .abort(abort),
    .step_limit(limit_s), .bp_addr(bp_addr), .bp_en(bp_en),
    .core_rst_o(s_core_rst), .step_o(s_step), .step_done_i(step_done_s),
    .pc_i(pc_i), .instr_i(instr_i), .illegal_i(illegal_i),
    .busy(s_busy), .done(s_done), .status(s_status),
    .instr_count(s_icnt), .cycle_count(s_ccnt)
  );

  function automatic bit bp_hit_ref(input logic [15:0] pc);
    for (int i = 0; i < 2; i++)
      if (bp_en[i] && bp_addr[i*16 +: 16] == pc) return 1'b1;
    return 1'b0;
  endfunction

  // Walks the step list: outcome, instructions executed and busy cycles spent.
  function automatic void model(input bit ss, input logic [31:0] lim, input int n,
                                output logic [2:0] st, output int cnt,
                                output int cyc);
    st = 3'd7; cnt = 0; cyc = ss ? 0 : RST;
    for (int k = 0; k < n; k++) begin
      cnt++;
      cyc += 2 + s_dly[k];
      if (s_ill[k] && s_ins[k] == SC) begin st = 3'd1; return; end
      if (s_ill[k])                   begin st = 3'd2; return; end
      if (bp_hit_ref(s_pc[k]))        begin st = 3'd3; return; end
      if (lim != 0 && cnt == lim)     begin st = 3'd4; return; end
      if (ss)                         begin st = 3'd0; return; end
    end
  endfunction

  task automatic do_run(input string name, input bit ss, input logic [31:0] lim,
                        input int n, input bit poke);
    logic [2:0] e_st;
    int e_cnt, e_cyc;
    int k, cd, it, rst_seen, first_step, steps_seen;
    bit fin;
    model(ss, lim, n, e_st, e_cnt, e_cyc);
    k = 0; cd = -1; it = 0; rst_seen = 0; first_step = -1; steps_seen = 0; fin = 1'b0;
    @(negedge clk); start = 1'b1; single_step = ss; step_limit = lim;
    @(negedge clk); start = 1'b0;
    while (!fin && it < 1000) begin
      step_done_i = 1'b0;
      if (done) fin = 1'b1;
      else begin
        start = (poke && it == 2);
        if (core_rst_o) rst_seen++;
        if (step_o) begin
          steps_seen++;
          if (first_step < 0) first_step = it;
        end
        if (cd == 0 && k < n) begin
          step_done_i = 1'b1; illegal_i = s_ill[k]; instr_i = s_ins[k]; pc_i = s_pc[k];
          k++; cd = -1;
        end else if (cd > 0) cd--;
        if (step_o) cd = (k < n) ? s_dly[k] : 0;
        @(negedge clk); it++;
      end
    end
    start = 1'b0; step_done_i = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s_timeout: done never seen after %0d cycles", name, it);
    end else begin
      checks++;
      if (status !== e_st) begin errors++; $display("FAIL %s_status: got %0d want %0d", name, status, e_st); end
      checks++;
      if (instr_count !== e_cnt) begin errors++; $display("FAIL %s_instr: got %0d want %0d", name, instr_count, e_cnt); end
      checks++;
      if (cycle_count !== e_cyc) begin errors++; $display("FAIL %s_cycles: got %0d want %0d", name, cycle_count, e_cyc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %0b want 0", name, busy); end
      checks++;
      if (rst_seen !== (ss ? 0 : RST)) begin errors++; $display("FAIL %s_core_rst_len: got %0d want %0d", name, rst_seen, ss ? 0 : RST); end
      checks++;
      if (first_step !== (ss ? 0 : RST)) begin errors++; $display("FAIL %s_first_step: got %0d want %0d", name, first_step, ss ? 0 : RST); end
      checks++;
      if (steps_seen !== e_cnt) begin errors++; $display("FAIL %s_steps: got %0d want %0d", name, steps_seen, e_cnt); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: done still %0b", name, done); end
    end
  endtask

  task automatic fill(input int n, input logic ill_last, input logic [15:0] ins_last);
    for (int k = 0; k < n; k++) begin
      s_ill[k] = 1'b0; s_ins[k] = 16'h1000 + 16'(k); s_pc[k] = 16'h0100 + 16'(2*k); s_dly[k] = k % 3;
    end
    s_ill[n-1] = ill_last; s_ins[n-1] = ins_last;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({core_rst_o, step_o, busy, done, status} !== 7'd0 || instr_count !== 0 || cycle_count !== 0) begin
      errors++; $display("FAIL reset_outputs: got rst=%0b step=%0b busy=%0b done=%0b st=%0d ic=%0d cc=%0d want all 0",
                         core_rst_o, step_o, busy, done, status, instr_count, cycle_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_success();
    bp_en = 2'b00;
    fill(5, 1'b1, SC);
    do_run("success", 1'b0, 32'd0, 5, 1'b1);
  endtask

  task automatic test_illegal();
    fill(3, 1'b1, 16'h0000);
    do_run("illegal", 1'b0, 32'd0, 3, 1'b0);
  endtask

  task automatic test_bp_vs_limit();
    bp_addr = {16'h0010, 16'h0555};
    fill(3, 1'b0, 16'h1234);
    s_pc[2] = 16'h0010;
    bp_en = 2'b10;
    do_run("bp_beats_limit", 1'b0, 32'd3, 3, 1'b0);
    bp_en = 2'b00;
    do_run("limit", 1'b0, 32'd3, 3, 1'b0);
  endtask

  task automatic test_single_step();
    fill(1, 1'b0, 16'h7C01);
    s_dly[0] = 1;
    do_run("single_step", 1'b1, 32'd0, 1, 1'b0);
  endtask

  task automatic test_abort();
    int g;
    // abort while waiting, no completion
    @(negedge clk); start = 1'b1; single_step = 1'b0; step_limit = '0;
    @(negedge clk); start = 1'b0;
    g = 0;
    while (!step_o && g < 50) begin @(negedge clk); g++; end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 3'd5 || instr_count !== 0) begin
      errors++; $display("FAIL abort_wait: done=%0b st=%0d ic=%0d want 1/5/0", done, status, instr_count);
    end
    // abort coincident with a success completion
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    g = 0;
    while (!step_o && g < 50) begin @(negedge clk); g++; end
    @(negedge clk); abort = 1'b1; step_done_i = 1'b1; illegal_i = 1'b1; instr_i = SC; pc_i = 16'h0200;
    @(negedge clk); abort = 1'b0; step_done_i = 1'b0; illegal_i = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 3'd1 || instr_count !== 1) begin
      errors++; $display("FAIL abort_race: done=%0b st=%0d ic=%0d want 1/1/1", done, status, instr_count);
    end
    // abort during core reset: no step is ever issued
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 3'd5 || step_o !== 1'b0 || core_rst_o !== 1'b0) begin
      errors++; $display("FAIL abort_core_rst: done=%0b st=%0d step=%0b rst=%0b want 1/5/0/0", done, status, step_o, core_rst_o);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    @(negedge clk); start = 1'b1; single_step = 1'b0; step_limit = '0;
    @(negedge clk); start = 1'b0;
    g = 0;
    while (!step_o && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_pre_busy: got %0b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_rst_o, step_o, busy, done, status} !== 7'd0 || instr_count !== 0 || cycle_count !== 0) begin
      errors++; $display("FAIL reset_mid_outputs: rst=%0b step=%0b busy=%0b done=%0b st=%0d cc=%0d want all 0",
                         core_rst_o, step_o, busy, done, status, cycle_count);
    end
    @(negedge clk); rst_n = 1'b1;
    fill(4, 1'b1, SC);
    do_run("after_reset", 1'b0, 32'd0, 4, 1'b0);
  endtask

  task automatic test_saturation();
    int k, g;
    bp_en = 2'b00;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    k = 0; g = 0;
    while (k < 20 && g < 400) begin
      if (s_step) begin
        @(negedge clk); step_done_s = 1'b1; illegal_i = 1'b0;
        instr_i = 16'($urandom); pc_i = 16'h0300 + 16'(k);
        @(negedge clk); step_done_s = 1'b0; k++;
      end else begin
        @(negedge clk); g++;
      end
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (s_done !== 1'b1 || s_status !== 3'd5 || s_icnt !== 4'hF || s_ccnt !== 4'hF) begin
      errors++; $display("FAIL saturation: done=%0b st=%0d ic=%h cc=%h want 1/5/F/F (steps %0d)",
                         s_done, s_status, s_icnt, s_ccnt, k);
    end
  endtask

  task automatic test_random();
    int n;
    bit ss;
    logic [31:0] lim;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        s_ill[k] = ($urandom_range(0, 4) == 0);
        s_ins[k] = ($urandom_range(0, 1) == 0) ? SC : 16'($urandom);
        case ($urandom_range(0, 2))
          0:       s_pc[k] = 16'h0010;
          1:       s_pc[k] = 16'h0020;
          default: s_pc[k] = 16'h4000 | 16'($urandom_range(0, 255));
        endcase
        s_dly[k] = $urandom_range(0, 3);
      end
      s_ill[n-1] = 1'b1;
      bp_addr = {16'h0010, 16'h0020};
      bp_en   = 2'($urandom_range(0, 3));
      lim     = $urandom_range(0, 5);
      ss      = ($urandom_range(0, 3) == 0);
      do_run($sformatf("rand%0d", r), ss, lim, n, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_success();
    test_illegal();
    test_bp_vs_limit();
    test_single_step();
    test_abort();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
